// File: rtl/mem_io_ctrl_if.sv
// CPU memory-port handshake between the CPU (master) and mem_io_ctrl (slave).
interface mem_io_ctrl_if #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 16
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;

  modport master (output req, we, addr, wdata, input rdata, ack);
  modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/mem_io_ctrl.sv
// Memory/I-O controller: decodes CPU accesses to RAM, LEDs, switches and HEX display.
// Optional HEX register and decoders are built when MMIO_HEX_EN is defined.
module mem_io_ctrl #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 16
) (
  input  logic              CLOCK_50,
  input  logic              rst_n,
  mem_io_ctrl_if.slave      bus,
  input  logic              halt,
  output logic [7:0]        ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic [9:0]        sw,
  output logic [9:0]        ledr,
  output logic [6:0]        hex0,
  output logic [6:0]        hex1,
  output logic [6:0]        hex2,
  output logic [6:0]        hex3
);

  localparam logic [ADDR_W-1:0] LED_ADDR = ADDR_W'(12'h100);
  localparam logic [ADDR_W-1:0] SW_ADDR  = ADDR_W'(12'h140);
  localparam logic [ADDR_W-1:0] HEX_ADDR = ADDR_W'(12'h180);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RDWAIT, S_DONE} state_t;

  state_t            state_q, state_d;
  logic              cap_we;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] rdata_q;
  logic              ack_q;
  logic [7:0]        led_q;
  logic [9:0]        sw_meta, sw_sync;
  logic              halt_flag, err_flag;

  logic              is_ram, is_led, is_sw, is_hex, unmapped;
  logic              accept, io_wr, io_rd, ram_ld, err_set, ack_d;
  logic [DATA_W-1:0] io_rdata;
  logic [15:0]       hex_val;

  // Target decode of the captured address
  always_comb begin
    is_ram   = (cap_addr[ADDR_W-1:8] == '0);
    is_led   = (cap_addr == LED_ADDR);
    is_sw    = (cap_addr == SW_ADDR);
`ifdef MMIO_HEX_EN
    is_hex   = (cap_addr == HEX_ADDR);
`else
    is_hex   = 1'b0;
`endif
    unmapped = cap_we ? ~(is_ram | is_led | is_hex)
                      : ~(is_ram | is_led | is_sw | is_hex);
  end

  always_comb begin
    io_rdata = '0;
    if (is_led)      io_rdata = DATA_W'(led_q);
    else if (is_sw)  io_rdata = DATA_W'(sw_sync);
    else if (is_hex) io_rdata = DATA_W'(hex_val);
  end

  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.req) state_d = S_ACCESS;
      S_ACCESS: state_d = (!cap_we && is_ram) ? S_RDWAIT : S_DONE;
      S_RDWAIT: state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // ram_we is gated by rst_n so a reset cycle can never corrupt RAM
  always_comb begin
    accept  = 1'b0;
    io_wr   = 1'b0;
    io_rd   = 1'b0;
    ram_ld  = 1'b0;
    err_set = 1'b0;
    ram_we  = 1'b0;
    ack_d   = (state_d == S_DONE);
    case (state_q)
      S_IDLE:   accept = bus.req;
      S_ACCESS: begin
        ram_we  = cap_we & is_ram & rst_n;
        io_wr   = cap_we & ~is_ram;
        io_rd   = ~cap_we & ~is_ram;
        err_set = unmapped;
      end
      S_RDWAIT: ram_ld = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      cap_we    <= 1'b0;
      cap_addr  <= '0;
      ram_wdata <= '0;
      rdata_q   <= '0;
      ack_q     <= 1'b0;
      led_q     <= '0;
      sw_meta   <= '0;
      sw_sync   <= '0;
      halt_flag <= 1'b0;
      err_flag  <= 1'b0;
    end else begin
      sw_meta   <= sw;
      sw_sync   <= sw_meta;
      halt_flag <= halt_flag | halt;
      ack_q     <= ack_d;
      if (accept) begin
        cap_we    <= bus.we;
        cap_addr  <= bus.addr;
        ram_wdata <= bus.wdata;
      end
      if (io_wr && is_led) led_q   <= ram_wdata[7:0];
      if (io_rd)           rdata_q <= io_rdata;
      if (ram_ld)          rdata_q <= ram_rdata;
      if (err_set)         err_flag <= 1'b1;
    end
  end

`ifdef MMIO_HEX_EN
  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: seg7 = 7'b1000000;
      4'h1: seg7 = 7'b1111001;
      4'h2: seg7 = 7'b0100100;
      4'h3: seg7 = 7'b0110000;
      4'h4: seg7 = 7'b0011001;
      4'h5: seg7 = 7'b0010010;
      4'h6: seg7 = 7'b0000010;
      4'h7: seg7 = 7'b1111000;
      4'h8: seg7 = 7'b0000000;
      4'h9: seg7 = 7'b0010000;
      4'hA: seg7 = 7'b0001000;
      4'hB: seg7 = 7'b0000011;
      4'hC: seg7 = 7'b1000110;
      4'hD: seg7 = 7'b0100001;
      4'hE: seg7 = 7'b0000110;
      default: seg7 = 7'b0001110;
    endcase
  endfunction

  // Segments are decoded on the write path so the outputs come straight from flops
  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      hex_val <= '0;
      hex0    <= 7'b1000000;
      hex1    <= 7'b1000000;
      hex2    <= 7'b1000000;
      hex3    <= 7'b1000000;
    end else if (io_wr && is_hex) begin
      hex_val <= ram_wdata[15:0];
      hex0    <= seg7(ram_wdata[3:0]);
      hex1    <= seg7(ram_wdata[7:4]);
      hex2    <= seg7(ram_wdata[11:8]);
      hex3    <= seg7(ram_wdata[15:12]);
    end
  end
`else
  assign hex_val = '0;
  assign hex0    = 7'h7F;
  assign hex1    = 7'h7F;
  assign hex2    = 7'h7F;
  assign hex3    = 7'h7F;
`endif

  assign ram_addr  = cap_addr[7:0];
  assign ledr      = {err_flag, halt_flag, led_q};
  assign bus.rdata = rdata_q;
  assign bus.ack   = ack_q;

endmodule

// File: tb/tb_mem_io_ctrl.sv
// Randomized self-checking bench for mem_io_ctrl against a transaction-level model.
module tb_mem_io_ctrl;

`ifdef MMIO_HEX_EN
  localparam bit HEX_EN = 1'b1;
`else
  localparam bit HEX_EN = 1'b0;
`endif

  localparam logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic        CLOCK_50;
  logic        rst_n;
  logic        halt;
  logic [7:0]  ram_addr;
  logic [15:0] ram_wdata;
  logic        ram_we;
  logic [15:0] ram_rdata;
  logic [9:0]  sw;
  logic [9:0]  ledr;
  logic [6:0]  hex0, hex1, hex2, hex3;

  mem_io_ctrl_if #(.ADDR_W(9), .DATA_W(16)) bus ();

  mem_io_ctrl dut (
    .CLOCK_50 (CLOCK_50), .rst_n (rst_n), .bus (bus), .halt (halt),
    .ram_addr (ram_addr), .ram_wdata (ram_wdata), .ram_we (ram_we), .ram_rdata (ram_rdata),
    .sw (sw), .ledr (ledr), .hex0 (hex0), .hex1 (hex1), .hex2 (hex2), .hex3 (hex3)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [15:0] ref_mem [256];
  logic [7:0]  ref_led;
  logic [15:0] ref_hex;
  logic        ref_err, ref_halt;
  logic [15:0] ref_rdata;
  logic [9:0]  ref_sw;
  logic        exp_ram_we;
  logic        chk_en;
  logic        ram_clr;

  function automatic logic [15:0] init_val(input int i);
    init_val = 16'(i * 937 + 16'h1357);
  endfunction

  // Board RAM: synchronous, one-cycle read
  logic [15:0] ram [256];
  always @(posedge CLOCK_50) begin
    if (ram_clr) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
    end else begin
      if (ram_we) ram[ram_addr] <= ram_wdata;
      ram_rdata <= ram[ram_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] hex_exp(input int d);
    hex_exp = HEX_EN ? SEG[ref_hex[d*4 +: 4]] : 7'h7F;
  endfunction

  // Every-cycle comparison of the status outputs against the model
  always @(negedge CLOCK_50) begin
    if (chk_en) begin
      chk("ledr", 32'(ledr), 32'({ref_err, ref_halt, ref_led}));
      chk("ram_we", 32'(ram_we), 32'(exp_ram_we));
      chk("hex0", 32'(hex0), 32'(hex_exp(0)));
      chk("hex1", 32'(hex1), 32'(hex_exp(1)));
      chk("hex2", 32'(hex2), 32'(hex_exp(2)));
      chk("hex3", 32'(hex3), 32'(hex_exp(3)));
    end
  end

  task automatic model_reset();
    ref_led = '0; ref_hex = '0; ref_err = 1'b0; ref_halt = 1'b0;
    ref_rdata = '0; exp_ram_we = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge CLOCK_50); #1;
    rst_n = 1'b1;
    model_reset();
    // let the switch synchronizer refill before any switch read
    repeat (2) begin @(posedge CLOCK_50); #1; end
  endtask

  task automatic halt_pulse();
    halt = 1'b1;
    @(posedge CLOCK_50); #1;
    halt = 1'b0;
    ref_halt = 1'b1;
  endtask

  // One CPU access; called while the DUT is idle, just after a rising edge
  task automatic acc(input logic w, input logic [8:0] a, input logic [15:0] d);
    int n;
    bit got, is_ram, hex_ok, mapped;
    int lat;
    logic [15:0] exp_rd;
    is_ram = (a < 9'h100);
    hex_ok = HEX_EN && (a == 9'h180);
    mapped = is_ram || (a == 9'h100) || hex_ok || (!w && a == 9'h140);
    lat    = (!w && is_ram) ? 3 : 2;
    if (is_ram)              exp_rd = ref_mem[a[7:0]];
    else if (a == 9'h100)    exp_rd = {8'h00, ref_led};
    else if (a == 9'h140)    exp_rd = {6'b0, ref_sw};
    else if (hex_ok)         exp_rd = ref_hex;
    else                     exp_rd = '0;
    bus.req = 1'b1; bus.we = w; bus.addr = a; bus.wdata = d;
    @(posedge CLOCK_50); #1;
    exp_ram_we = w && is_ram;
    if (is_ram) chk("ram_addr", 32'(ram_addr), 32'(a[7:0]));
    n = 1; got = 1'b0;
    while (n <= 6 && !got) begin
      if (bus.ack) got = 1'b1;
      else begin
        @(posedge CLOCK_50); #1;
        n++;
        if (n == 2) begin
          exp_ram_we = 1'b0;
          if (w) begin
            if (is_ram)          ref_mem[a[7:0]] = d;
            else if (a == 9'h100) ref_led = d[7:0];
            else if (hex_ok)     ref_hex = d;
          end else ref_rdata = exp_rd;
          if (!mapped) ref_err = 1'b1;
        end
      end
    end
    chk("ack_latency", 32'(n), 32'(lat));
    chk("rdata", 32'(bus.rdata), 32'(ref_rdata));
    bus.req = 1'b0;
    @(posedge CLOCK_50); #1;
    chk("ack_pulse", 32'(bus.ack), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [8:0] a;
    int r;
    rst_n = 1'b0; halt = 1'b0; sw = '0; ram_clr = 1'b1; chk_en = 1'b0;
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
    ref_sw = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    model_reset();
    repeat (2) begin @(posedge CLOCK_50); #1; end
    ram_clr = 1'b0;
    rst_n = 1'b1;
    chk_en = 1'b1;

    chk("rst_ack", 32'(bus.ack), 32'd0);
    chk("rst_ledr", 32'(ledr), 32'd0);
    chk("rst_rdata", 32'(bus.rdata), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_hex0", 32'(hex0), HEX_EN ? 32'h40 : 32'h7F);
    chk("rst_hex3", 32'(hex3), HEX_EN ? 32'h40 : 32'h7F);

    // RAM round trip
    acc(1'b1, 9'h014, 16'hABCD);
    acc(1'b0, 9'h014, 16'h0000);
    chk("rt_rdata", 32'(bus.rdata), 32'h0000ABCD);

    // I/O registers
    acc(1'b1, 9'h100, 16'h00A5);
    chk("led_a5", 32'(ledr[7:0]), 32'hA5);
    acc(1'b1, 9'h180, 16'h1234);
    chk("hex3_1", 32'(hex3), HEX_EN ? 32'h79 : 32'h7F);
    chk("hex2_2", 32'(hex2), HEX_EN ? 32'h24 : 32'h7F);
    chk("hex1_3", 32'(hex1), HEX_EN ? 32'h30 : 32'h7F);
    chk("hex0_4", 32'(hex0), HEX_EN ? 32'h19 : 32'h7F);
    sw = 10'h2AA;
    repeat (3) begin @(posedge CLOCK_50); #1; end
    ref_sw = sw;
    acc(1'b0, 9'h140, 16'h0000);
    chk("sw_read", 32'(bus.rdata), 32'h02AA);

    // Unmapped accesses
    do_reset();
    acc(1'b1, 9'h1FF, 16'h5555);
    chk("err_set", 32'(ledr[9]), 32'd1);
    acc(1'b0, 9'h014, 16'h0000);
    acc(1'b0, 9'h1C0, 16'h0000);
    chk("unmapped_rd", 32'(bus.rdata), 32'd0);
    chk("err_sticky", 32'(ledr[9]), 32'd1);

    // HALT indicator
    halt_pulse();
    chk("halt_set", 32'(ledr[8]), 32'd1);
    repeat (3) begin @(posedge CLOCK_50); #1; end
    chk("halt_sticky", 32'(ledr[8]), 32'd1);
    do_reset();
    chk("flags_clear", 32'(ledr), 32'd0);

    // Reset during the ACCESS cycle of a RAM write
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = 9'h020; bus.wdata = 16'hDEAD;
    @(posedge CLOCK_50); #1;
    rst_n = 1'b0; bus.req = 1'b0;
    @(posedge CLOCK_50); #1;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      chk("abort_no_ack", 32'(bus.ack), 32'd0);
      @(posedge CLOCK_50); #1;
    end
    acc(1'b0, 9'h020, 16'h0000);
    chk("abort_ram", 32'(bus.rdata), 32'(init_val(32)));

    // Randomized traffic
    for (int it = 0; it < 300; it++) begin
      r = $urandom_range(0, 99);
      if (r < 3) do_reset();
      else if (r < 9) halt_pulse();
      else if (r < 15) begin
        sw = 10'($urandom);
        repeat (3) begin @(posedge CLOCK_50); #1; end
        ref_sw = sw;
      end
      r = $urandom_range(0, 9);
      case (r)
        5:       a = 9'h100;
        6:       a = 9'h140;
        7:       a = 9'h180;
        8:       a = 9'($urandom);
        9:       a = 9'h1C0;
        default: a = {1'b0, 8'($urandom)};
      endcase
      acc(1'($urandom), a, 16'($urandom));
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_io_ctrl.md
# mem_io_ctrl

Memory and I/O controller between the CPU's memory port and the board-level resources in lab7bonus_top. It decodes each CPU access into one of four targets: main RAM (a synchronous, 1-cycle-read block), the LED register, the synchronized switches, or the HEX display register. Every access completes with a one-cycle `ack` pulse. The block also owns the sticky HALT and bus-error indicators on LEDR[8] and LEDR[9], which top-level benches watch for end of program.

## Interface
- `ADDR_W`, 9, CPU word-address width
- `DATA_W`, 16, data width
- `CLOCK_50`  in  1  clock; all logic on rising edge
- `rst_n`  in  1  reset, synchronous, active-low (driven from KEY[1])
- `req`  in  1  CPU access request, held until `ack`
- `we`  in  1  1 = write, 0 = read; valid with `req`
- `addr`  in  ADDR_W  word address; valid with `req`
- `wdata`  in  DATA_W  write data; valid with `req`
- `rdata`  out  DATA_W  read data; valid in the `ack` cycle
- `ack`  out  1  one-cycle completion pulse
- `halt`  in  1  CPU is in HALT state
- `ram_addr`  out  8  RAM word address
- `ram_wdata`  out  DATA_W  RAM write data
- `ram_we`  out  1  RAM write enable
- `ram_rdata`  in  DATA_W  RAM read data, valid 1 cycle after address
- `sw`  in  10  raw slide switches (asynchronous)
- `ledr`  out  10  LEDs
- `hex0`..`hex3`  out  7 each  seven-segment outputs, active-low, segment order g..a

## Operation
- **Address map**
  - 0x000–0x0FF: RAM.
  - 0x100: LED register. A write stores `wdata[7:0]` on `ledr[7:0]`. A read returns `{8'b0, led}`.
  - 0x140: switches. Read-only; returns `{6'b0, sw_sync}`.
  - 0x180: HEX register. 16-bit, read/write.
  - Any other address is unmapped.
- **Unmapped accesses**
  - A read returns 0.
  - A write is discarded.
  - In both cases `ack` is still given and `ledr[9]` (bus error) is set. It stays set until reset.
- **Writes to read-only locations:** a write to 0x140 is treated as unmapped.
- **HALT indicator:** `ledr[8]` is set on the first cycle `halt` is sampled high. It stays set until reset.
- **Switch synchronizer:** `sw` passes through a 2-flop synchronizer to form `sw_sync`.
- **HEX display:** `hex0` shows HEX register bits [3:0], up to `hex3` showing bits [15:12], each as a full 0–F hex decode. The digit "0" is 7'b1000000.
- **FSM states:**
  - IDLE: when `req`=1, capture `we`, `addr`, `wdata` and go to ACCESS. Otherwise stay in IDLE.
  - ACCESS: drive `ram_addr` = captured `addr[7:0]` and `ram_wdata` = captured data. I/O writes take effect at the end of this cycle. If the access is a RAM read, go to RDWAIT; otherwise go to DONE.
  - RDWAIT: capture `ram_rdata` into `rdata`, then go to DONE.
  - DONE: `ack`=1, then go to IDLE.
- `ram_we` = (state==ACCESS) & captured `we` & RAM target & `rst_n`. A cycle with `rst_n` low therefore never writes RAM.
- `req` is sampled only in IDLE. The CPU deasserts `req` in the cycle after it sees `ack`; if `req` is still high in IDLE, that is a new access.
- **Reset (`rst_n` low at a rising edge):**
  - Next state is IDLE and any in-flight access is aborted with no `ack`.
  - `ack`=0, `rdata`=0, `ram_addr`=0, `ram_wdata`=0.
  - LED register = 0 and `ledr`=0.
  - HEX register = 0, so all four digits show "0".
  - Synchronizer flops = 0.

## Timing
- Request accepted at edge 0, i.e. `req` is high in IDLE.
- Write (any target), I/O read, or unmapped access: `ack` is high in cycle 2, giving 3-cycle occupancy.
- RAM read: the address is presented in cycle 1, data is captured at the end of cycle 2, and `ack` is high in cycle 3.
- `rdata` holds its value until the next read completes.
- Switch change to visibility in `sw_sync`: 2 edges.
- `ledr[8]` rises one cycle after `halt` is first high.
- If a new `halt` arrives in the same cycle as a bus error, both flags set independently.

## Configuration
- `MMIO_HEX_EN` defined:
  - HEX register and decoders are present, as described above.
- `MMIO_HEX_EN` not defined:
  - No HEX register or decoders are built.
  - `hex0`..`hex3` are held at 7'h7F (all segments off).
  - Address 0x180 is unmapped: reads return 0 and set `ledr[9]`.

## Test plan
- **Reset:** hold `rst_n`=0 for 1 cycle, then release. Expect `ack`=0, `ledr`=0, each hex digit = 7'b1000000, and first `req` accepted the cycle after release.
- **RAM round trip:** write 0xABCD to 0x014, then read 0x014. Expect `ram_we` high for exactly 1 cycle with `ram_addr`=0x14, and the read returns `rdata`=0xABCD with `ack` in cycle 3.
- **I/O:** write 0x00A5 to 0x100, then 0x1234 to 0x180. Expect `ledr[7:0]`=0xA5, hex3..hex0 showing "1234", and each `ack` in cycle 2. Set `sw`=10'h2AA and read 0x140 three or more cycles later: expect 0x02AA.
- **Unmapped access:** write 0x1FF. Expect `ack`, no `ram_we`, and `ledr[9]`=1 sticky until `rst_n` low. Then read 0x1C0: expect `rdata`=0.
- **HALT:** pulse `halt` for 1 cycle. Expect `ledr[8]` to rise the next cycle and stay high until reset.
- **Reset mid-access:** assert `rst_n`=0 during ACCESS of a RAM write to 0x020. Expect no `ram_we`, no `ack`, and RAM[0x20] unchanged.
